// File: rtl/fetch_line_buffer.sv
// Single-line fetch buffer on the fetch memory sub-unit interface.
// Hits return one cycle after the request. A miss bursts the whole aligned
// line in over the mem_* port and then returns the requested word.
module fetch_line_buffer #(
  parameter  int LINE_WORDS = 4,
  localparam int LINE_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_request,
  input  logic [31:0]       addr,
  input  logic              re,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       data_in,
  output logic              ready,
  output logic              data_valid,
  output logic [31:0]       data_out,
  input  logic              invalidate,
  output logic              mem_request,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_len,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int TAG_W = 30 - LINE_W;

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_FILL, RESPOND} state_t;

  state_t            state;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [31:0]       line_data [LINE_WORDS];
  logic [TAG_W-1:0]  req_tag;
  logic [LINE_W-1:0] req_idx;
  logic [LINE_W:0]   beat_cnt;
  logic              inv_pending;

  logic [TAG_W-1:0]  tag;
  logic [LINE_W-1:0] idx;
  logic [LINE_W-1:0] beat_idx;
  logic              can_accept;
  logic              accept;
  logic              hit;
  logic              last_beat;
  logic              unused;

  assign idx        = addr[2 +: LINE_W];
  assign tag        = addr[31 -: TAG_W];
  assign beat_idx   = beat_cnt[LINE_W-1:0];
  // RESPOND accepts like IDLE, and sees the line that was just filled.
  assign can_accept = (state == IDLE) || (state == RESPOND);
  assign accept     = can_accept && new_request && re && !we;
  assign hit        = line_valid && (tag == line_tag);
  assign last_beat  = mem_rvalid && (beat_cnt == (LINE_W+1)'(LINE_WORDS-1));

  assign mem_addr   = {req_tag, {(LINE_W+2){1'b0}}};
  assign mem_len    = LINE_W'(LINE_WORDS-1);

  // Write-side byte enables and data are never used by a read-only unit.
  assign unused     = ^{be, data_in, addr[1:0]};

  // Line storage: beats land in ascending word order during the fill.
  always_ff @(posedge clk) begin
    if (!rst && state == MISS_FILL && mem_rvalid)
      line_data[beat_idx] <= mem_rdata;
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      line_valid  <= 1'b0;
      line_tag    <= '0;
      req_tag     <= '0;
      req_idx     <= '0;
      beat_cnt    <= '0;
      inv_pending <= 1'b0;
      ready       <= 1'b1;
      data_valid  <= 1'b0;
      data_out    <= '0;
      mem_request <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE, RESPOND: begin
          inv_pending <= 1'b0;
          // Same-cycle request below still sees the pre-invalidate line.
          if (invalidate) line_valid <= 1'b0;
          if (accept && hit) begin
            data_valid <= 1'b1;
            data_out   <= line_data[idx];
            state      <= IDLE;
            ready      <= 1'b1;
          end else if (accept) begin
            req_tag     <= tag;
            req_idx     <= idx;
            state       <= MISS_REQ;
            ready       <= 1'b0;
            mem_request <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        MISS_REQ: begin
          if (invalidate) inv_pending <= 1'b1;
          if (mem_ack) begin
            mem_request <= 1'b0;
            beat_cnt    <= '0;
            line_valid  <= 1'b0;
            state       <= MISS_FILL;
          end
        end
        MISS_FILL: begin
          if (invalidate) inv_pending <= 1'b1;
          if (mem_rvalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              line_tag   <= req_tag;
              line_valid <= !(inv_pending || invalidate);
              data_valid <= 1'b1;
              // The final beat is not in line_data yet; forward it directly.
              data_out   <= (req_idx == beat_idx) ? mem_rdata : line_data[req_idx];
              state      <= RESPOND;
              ready      <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Bench for fetch_line_buffer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_fetch_line_buffer;

  localparam int LW = 4;
  localparam int WB = 2;

  logic          clk = 1'b0;
  logic          rst, new_request, re, we, invalidate;
  logic [31:0]   addr, data_in;
  logic [3:0]    be;
  logic          ready, data_valid, mem_request;
  logic [31:0]   data_out, mem_addr;
  logic [WB-1:0] mem_len;
  logic          mem_ack, mem_rvalid;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  fetch_line_buffer #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .new_request(new_request), .addr(addr), .re(re),
    .we(we), .be(be), .data_in(data_in), .ready(ready), .data_valid(data_valid),
    .data_out(data_out), .invalidate(invalidate), .mem_request(mem_request),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Backing memory contents; line 0x1000 holds 0xA0..0xA3.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
    if (line == 32'h1000) return 32'hA0 + 32'(i);
    return {line[23:4], 4'(i), 8'h5C} ^ 32'h3C00_0000;
  endfunction

  // ---------------- transaction model ----------------
  bit          live = 0;
  logic        e_ready = 1'b1, e_dv = 1'b0, e_mreq = 1'b0;
  logic [31:0] e_do = '0, e_maddr = '0;
  bit          m_valid, busy, acked, p_inv;
  int unsigned m_tag, p_tag;
  int          got, p_idx;
  logic [31:0] m_data [LW];

  initial forever begin : model
    bit acc, nv;
    int unsigned t;
    int ix;
    logic [31:0] nd;
    @(posedge clk);
    if (rst) begin
      live = 1; m_valid = 0; busy = 0; acked = 0;
      e_ready = 1; e_dv = 0; e_do = '0; e_mreq = 0;
    end else begin
      nv = 0; nd = '0;
      if (!busy) begin
        acc = new_request && re && !we;
        t   = addr >> (2 + WB);
        ix  = int'((addr >> 2) % LW);
        if (acc) begin
          if (m_valid && t == m_tag) begin
            nv = 1; nd = m_data[ix];
          end else begin
            busy = 1; acked = 0; got = 0; p_tag = t; p_idx = ix; p_inv = 0;
          end
        end
        if (invalidate) m_valid = 0;
      end else begin
        if (invalidate) p_inv = 1;
        if (!acked) begin
          if (mem_ack) begin acked = 1; m_valid = 0; end
        end else if (mem_rvalid) begin
          m_data[got] = mem_rdata;
          got++;
          if (got == LW) begin
            busy = 0; m_tag = p_tag; m_valid = !p_inv;
            nv = 1; nd = m_data[p_idx];
          end
        end
      end
      e_dv    = nv;
      if (nv) e_do = nd;
      e_ready = !busy;
      e_mreq  = busy && !acked;
      e_maddr = p_tag << (2 + WB);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      chk("ready", ready, e_ready);
      chk("data_valid", data_valid, e_dv);
      if (e_dv) chk("data_out", data_out, e_do);
      chk("mem_request", mem_request, e_mreq);
      if (e_mreq) chk("mem_addr", mem_addr, e_maddr);
      chk("mem_len", mem_len, LW - 1);
    end
  end

  // ---------------- memory responder + stepping ----------------
  int          ph = 0, cnt = 0, mr_beat = 0, last_beat_cyc = 0;
  logic [31:0] mr_line = '0;
  bit          rand_mode = 0, stray = 0;
  int          ack_dly = 2, gap_pct = 0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = $urandom;
    if (rst) ph = 0;
    else if (ph == 2) begin
      if ($urandom_range(0, 99) >= gap_pct) begin
        mem_rvalid = 1;
        mem_rdata  = mem_word(mr_line, mr_beat);
        if (mr_beat == LW - 1) begin ph = 0; last_beat_cyc = cyc; end
        mr_beat++;
      end
    end else begin
      if (ph == 0 && mem_request) begin
        ph = 1; mr_line = mem_addr;
        cnt = rand_mode ? int'($urandom_range(0, 3)) : ack_dly;
      end
      if (ph == 1) begin
        if (cnt == 0) begin mem_ack = 1; ph = 2; mr_beat = 0; end
        else cnt--;
      end else if (stray && $urandom_range(0, 7) == 0) mem_rvalid = 1;
    end
  endtask

  task automatic req(input logic [31:0] a);
    new_request = 1; re = 1; we = 0; addr = a;
    tick();
    new_request = 0;
  endtask

  task automatic wait_dv(input string nm, input logic [31:0] exp);
    int at;
    at = -1;
    for (int i = 0; i < 60; i++) begin
      if (data_valid) begin at = cyc; break; end
      tick();
    end
    if (at < 0) begin
      tests++; fails++;
      $display("FAIL %s: got no data_valid expected %h within 60 cycles", nm, exp);
    end else chk(nm, data_out, exp);
  endtask

  task automatic wait_beat2(input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_rvalid && mr_beat == 2) begin found = 1; break; end
    end
    chk(nm, found, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, at;
    bit early;
    logic [31:0] lines [4];
    lines = '{32'h1000, 32'h2000, 32'h3000, 32'h8000_0040};
    rst = 1; new_request = 0; re = 0; we = 0; invalidate = 0;
    addr = '0; data_in = '0; be = '0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = '0;
    tick(); tick();
    chk("rst_ready", ready, 1);
    chk("rst_dv", data_valid, 0);
    chk("rst_mreq", mem_request, 0);
    chk("rst_dout", data_out, 0);
    rst = 0;

    // Cold miss
    req(32'h1008);
    chk("cold_ready", ready, 0);
    chk("cold_mreq", mem_request, 1);
    chk("cold_maddr", mem_addr, 32'h1000);
    chk("cold_mlen", mem_len, 3);
    early = 0; at = -1;
    for (int i = 0; i < 60; i++) begin
      if (data_valid) begin at = cyc; break; end
      if (ready) early = 1;
      tick();
    end
    chk("cold_ready_low", early, 0);
    chk("cold_data", data_out, 32'hA2);
    chk("cold_latency", at - last_beat_cyc, 1);
    chk("respond_ready", ready, 1);

    // Hit streaming, starting in the response cycle
    begin
      logic [31:0] ha [3];
      logic [31:0] hd [3];
      ha = '{32'h1000, 32'h1004, 32'h100C};
      hd = '{32'hA0, 32'hA1, 32'hA3};
      new_request = 1; re = 1; we = 0;
      for (int k = 0; k < 3; k++) begin
        addr = ha[k];
        tick();
        chk("hit_dv", data_valid, 1);
        chk("hit_data", data_out, hd[k]);
        chk("hit_no_mreq", mem_request, 0);
      end
      new_request = 0;
      tick();
      chk("hit_done_dv", data_valid, 0);
    end

    // Hit followed by miss
    new_request = 1; re = 1; we = 0; addr = 32'h1004;
    tick();
    chk("hm_hit_dv", data_valid, 1);
    chk("hm_hit_data", data_out, 32'hA1);
    addr = 32'h2000;
    tick();
    new_request = 0;
    chk("hm_dv_gap", data_valid, 0);
    chk("hm_mreq", mem_request, 1);
    chk("hm_maddr", mem_addr, 32'h2000);
    wait_dv("hm_miss_data", mem_word(32'h2000, 0));

    // Invalidate during fill beat 1
    req(32'h3004);
    wait_beat2("inv_beat1_seen");
    invalidate = 1;
    tick();
    invalidate = 0;
    wait_dv("inv_data", mem_word(32'h3000, 1));
    req(32'h3000);
    chk("inv_remiss_ready", ready, 0);
    chk("inv_remiss_mreq", mem_request, 1);
    wait_dv("inv_refill", mem_word(32'h3000, 0));
    req(32'h3008);
    chk("refill_hit_dv", data_valid, 1);
    chk("refill_hit_data", data_out, mem_word(32'h3000, 2));

    // Reset mid-fill: two beats accepted, third collides with reset
    req(32'h4000);
    wait_beat2("rst_beat1_seen");
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rstfill_ready", ready, 1);
    chk("rstfill_dv", data_valid, 0);
    chk("rstfill_mreq", mem_request, 0);
    n = 0;
    repeat (8) begin
      tick();
      if (data_valid) n++;
      if (mem_request) n++;
    end
    chk("rstfill_quiet", n, 0);
    req(32'h4000);
    chk("rstfill_remiss", mem_request, 1);
    wait_dv("rstfill_data", mem_word(32'h4000, 0));
    tick();

    // Dropped requests: we=1, then re=0
    new_request = 1; re = 1; we = 1; addr = 32'h4000;
    tick();
    chk("drop_we_dv", data_valid, 0);
    re = 0; we = 0;
    tick();
    new_request = 0;
    chk("drop_re_dv", data_valid, 0);
    chk("drop_ready", ready, 1);
    chk("drop_mreq", mem_request, 0);
    req(32'h4004);
    chk("drop_hit_dv", data_valid, 1);
    chk("drop_hit_data", data_out, mem_word(32'h4000, 1));

    // Requests while busy are ignored
    req(32'h5000);
    new_request = 1; re = 1; we = 0; addr = 32'h4008;
    n = 0;
    tick(); tick();
    new_request = 0;
    for (int i = 0; i < 20; i++) begin
      if (data_valid) n++;
      tick();
    end
    chk("illegal_dv_count", n, 1);
    req(32'h5004);
    chk("illegal_hit_data", data_out, mem_word(32'h5000, 1));

    // Randomized traffic
    rand_mode = 1; gap_pct = 30; stray = 1;
    repeat (2500) begin
      new_request = ($urandom_range(0, 9) < 6);
      addr = lines[$urandom_range(0, 3)] | (32'($urandom_range(0, 3)) << 2)
             | 32'($urandom_range(0, 3));
      re = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 9) == 0);
      invalidate = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    new_request = 0; invalidate = 0; rst = 0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_line_buffer.md
Name: fetch_line_buffer

Overview:
- Read-only responder sub-unit on the fetch memory sub-unit interface (new_request/addr/ready/data_valid/data_out). It sits behind the fetch stage alongside local memory, icache and bus sub-units.
- Holds one line of LINE_WORDS words. Hits return in 1 cycle.
- Misses fetch the whole aligned line over a simple burst-read port, then return the requested word.
- Supports an ifence-style invalidate.

Parameters:
- LINE_WORDS, 4: words per line; power of two, ≥2.
- LINE_W, $clog2(LINE_WORDS): word-index width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- new_request  in  1  request strobe; valid only while ready=1
- addr  in  32  byte address; bits [1:0] ignored
- re  in  1  read enable; must be 1 for a request to be accepted
- we  in  1  write enable; requests with we=1 are dropped
- be  in  4  unused
- data_in  in  32  unused
- ready  out  1  can accept a request this cycle
- data_valid  out  1  one-cycle response strobe
- data_out  out  32  response word; valid only while data_valid=1
- invalidate  in  1  clear line valid (ifence)
- mem_request  out  1  burst read request; held until mem_ack
- mem_addr  out  32  line-aligned burst address
- mem_len  out  LINE_W  beats minus one; constant LINE_WORDS-1
- mem_ack  in  1  burst request accepted
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  32  read beat data

Behaviour:
Address split:
- idx = addr[2+:LINE_W]; tag = addr[31:2+LINE_W].
- mem_addr = {tag, (LINE_W+2)'b0}.

State: line_valid, line_tag, line_data[LINE_WORDS], req_idx, beat_cnt[LINE_W:0], FSM {IDLE, MISS_REQ, MISS_FILL, RESPOND}.

Reset:
- state=IDLE; line_valid=0; ready=1; data_valid=0; mem_request=0; data_out=0; beat_cnt=0.
- Reset during a miss abandons it with no response. The memory side is reset together with this block; stale beats after reset are out of scope.

IDLE:
- ready=1.
- Accepted request = new_request & re & ~we.
- Hit (line_valid & tag==line_tag):
  - data_valid=1 and data_out=line_data[idx] on the next cycle (latency 1).
  - Stay in IDLE, so back-to-back hits run at one per cycle.
- Miss:
  - Latch tag and idx.
  - ready=0 from the next cycle.
  - Go to MISS_REQ.
  - A hit response from the previous cycle still completes normally.

MISS_REQ:
- mem_request=1, mem_addr driven.
- On mem_ack: beat_cnt=0, line_valid=0, go to MISS_FILL.
- mem_request drops the cycle after ack.

MISS_FILL:
- Each mem_rvalid writes line_data[beat_cnt] and increments beat_cnt. Beats arrive in ascending word order.
- On beat LINE_WORDS-1: line_tag=latched tag, line_valid=1 (unless an invalidate is pending), go to RESPOND.

RESPOND:
- data_valid=1, data_out=line_data[req_idx]. This is the cycle after the last beat, so miss latency = ack wait + LINE_WORDS beats + 1.
- ready=1 in this cycle; a new request may be accepted and is evaluated against the freshly filled line.
- Next state is IDLE.

Ordering and protocol:
- Responses are strictly in request order; at most 2 responses are outstanding (one registered hit, one miss).
- Every accepted request gets exactly one data_valid, including across fetch flushes. The initiator discards responses it does not want.
- new_request while ready=0 is a protocol violation: ignored, no response.
- A dropped request (we=1 or re=0) produces no response and no state change.

Invalidate:
- In IDLE or RESPOND: line_valid=0 next cycle. A same-cycle request is evaluated against the pre-invalidate state.
- In MISS_REQ or MISS_FILL: set invalidate_pending. The pending miss still completes and responds with the fetched word, but line_valid stays 0 afterwards. invalidate_pending clears on entry to IDLE.

Simultaneous events:
- mem_rvalid is ignored outside MISS_FILL.
- rst overrides all other inputs.

Test Plan:
- Cold miss:
  - Stimulus: after reset, request addr=0x0000_1008; mem_ack after 2 cycles; beats 0xA0,0xA1,0xA2,0xA3.
  - Response: mem_addr=0x1000, mem_len=3; ready=0 during the miss; data_valid with data_out=0xA2 exactly 1 cycle after the last beat.
- Hit streaming:
  - Stimulus: then requests 0x1000, 0x1004, 0x100C on consecutive cycles.
  - Response: data_valid on 3 consecutive cycles with 0xA0, 0xA1, 0xA3; no mem_request.
- Hit followed by miss:
  - Stimulus: request 0x1004, then 0x2000 next cycle.
  - Response: 0xA1 returned first; mem_request with mem_addr=0x2000; responses stay in order.
- Invalidate during fill:
  - Stimulus: invalidate pulse in MISS_FILL beat 1 for miss addr 0x3004.
  - Response: data_valid returns beat 1 data; a subsequent request to 0x3000 misses again.
- Reset mid-fill:
  - Stimulus: rst after 2 of 4 beats.
  - Response: ready=1, data_valid never asserts, mem_request=0; the next request to the same line misses.
- Dropped and illegal requests:
  - Stimulus: request with we=1 at 0x1000, and new_request while ready=0.
  - Response: no data_valid and no state change for either.
